// File: rtl/minisrc_pkg.sv
// Shared MiniSRC control definitions: opcodes, ALU/MY codes, decode classes and sequencer states.
// No logic; imported by the decoder and the sequencer.
package minisrc_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_DIV = 4'b0100;
    localparam logic [3:0] ALU_MUL = 4'b0101;

    localparam logic [1:0] MY_RZ1 = 2'd0;
    localparam logic [1:0] MY_RZ0 = 2'd1;
    localparam logic [1:0] MY_MEM = 2'd2;
    localparam logic [1:0] MY_RET = 2'd3;

    typedef enum logic [2:0] {
        CL_LD, CL_ST, CL_ALU, CL_IMM, CL_MULDIV, CL_NOP, CL_HALT, CL_ILL
    } op_class_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_WR, S_WB_HI, S_WR_HI, S_HALT
    } state_t;

endpackage

// File: rtl/minisrc_decode.sv
// Combinational instruction decode: op class, ALU code, B-mux select, immediate, register addresses.
// Zero latency; no handshake, follows ir every cycle.
module minisrc_decode
    import minisrc_pkg::*;
(
    input  logic [31:0] ir,
    output op_class_t   op_class,
    output logic [3:0]  alu_code,
    output logic        mb_sel,
    output logic [31:0] imm,
    output logic [3:0]  ra,
    output logic [3:0]  addr_a,
    output logic [3:0]  addr_b
);

    logic [3:0] rb;
    logic [3:0] rc;

    assign ra  = ir[26:23];
    assign rb  = ir[22:19];
    assign rc  = ir[18:15];
    assign imm = {{13{ir[18]}}, ir[18:0]};

    always_comb begin
        op_class = CL_ILL;
        alu_code = ALU_ADD;
        mb_sel   = 1'b0;
        case (ir[31:27])
            OP_LD:   begin op_class = CL_LD;  mb_sel = 1'b1; end
            OP_ST:   begin op_class = CL_ST;  mb_sel = 1'b1; end
            OP_ADD:  op_class = CL_ALU;
            OP_SUB:  begin op_class = CL_ALU; alu_code = ALU_SUB; end
            OP_AND:  begin op_class = CL_ALU; alu_code = ALU_AND; end
            OP_OR:   begin op_class = CL_ALU; alu_code = ALU_OR;  end
            OP_ADDI: begin op_class = CL_IMM; mb_sel = 1'b1; end
            OP_ANDI: begin op_class = CL_IMM; mb_sel = 1'b1; alu_code = ALU_AND; end
            OP_ORI:  begin op_class = CL_IMM; mb_sel = 1'b1; alu_code = ALU_OR;  end
            OP_DIV:  begin op_class = CL_MULDIV; alu_code = ALU_DIV; end
            OP_MUL:  begin op_class = CL_MULDIV; alu_code = ALU_MUL; end
            OP_NOP:  op_class = CL_NOP;
            OP_HALT: op_class = CL_HALT;
            default: op_class = CL_ILL;
        endcase
    end

    // Stores read the data register (ra) on port B; nop/halt/illegal read nothing.
    always_comb begin
        addr_a = 4'd0;
        addr_b = 4'd0;
        case (op_class)
            CL_LD, CL_IMM: addr_a = rb;
            CL_ST:         begin addr_a = rb; addr_b = ra; end
            CL_ALU, CL_MULDIV: begin addr_a = rb; addr_b = rc; end
            default: ;
        endcase
    end

endmodule

// File: rtl/minisrc_control.sv
// MiniSRC multi-cycle sequencer; all strobes registered, one stage per cycle (ALU 5, mul/div 7, ld 6+ack, st 4+ack).
// Waits in FETCH for instr_valid and in MEM for mem_ack; a MEM stall of MEM_TIMEOUT cycles raises bus_error and halts.
module minisrc_control
    import minisrc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic [31:0] ir_in,
    input  logic        instr_valid,
    input  logic        mem_ack,
    output logic        instr_req,
    output logic        ir_enable,
    output logic        ra_enable,
    output logic        rb_enable,
    output logic        rm_enable,
    output logic        rz0_enable,
    output logic        rz1_enable,
    output logic        ry_enable,
    output logic        mb_select,
    output logic [1:0]  my_select,
    output logic [3:0]  alu_control,
    output logic [31:0] imm_out,
    output logic [3:0]  rf_addr_a,
    output logic [3:0]  rf_addr_b,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic        pc_enable,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        illegal_op,
    output logic        bus_error,
    output logic        halted,
    output logic [31:0] retired
);

    state_t      state;
    state_t      nxt;
    logic [31:0] tcnt;
    logic        mem_timeout;

    op_class_t   dec_class;
    logic [3:0]  dec_alu;
    logic        dec_mb;
    logic [3:0]  dec_ra;
    logic [3:0]  dec_addr_a;
    logic [3:0]  dec_addr_b;

    minisrc_decode u_decode (
        .ir       (ir_in),
        .op_class (dec_class),
        .alu_code (dec_alu),
        .mb_sel   (dec_mb),
        .imm      (imm_out),
        .ra       (dec_ra),
        .addr_a   (dec_addr_a),
        .addr_b   (dec_addr_b)
    );

    // An ack arriving on the final allowed cycle still completes the access.
    always_comb begin
        nxt         = state;
        mem_timeout = 1'b0;
        case (state)
            S_FETCH:  if (instr_valid) nxt = S_DECODE;
            S_DECODE: begin
                case (dec_class)
                    CL_HALT:        nxt = S_HALT;
                    CL_NOP, CL_ILL: nxt = S_FETCH;
                    default:        nxt = S_EXEC;
                endcase
            end
            S_EXEC:   nxt = (dec_class == CL_LD || dec_class == CL_ST) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ack) begin
                    nxt = (dec_class == CL_LD) ? S_WB : S_FETCH;
                end else if (MEM_TIMEOUT != 0 && tcnt == MEM_TIMEOUT - 1) begin
                    mem_timeout = 1'b1;
                    nxt         = S_HALT;
                end
            end
            S_WB:     nxt = S_WR;
            S_WR:     nxt = (dec_class == CL_MULDIV) ? S_WB_HI : S_FETCH;
            S_WB_HI:  nxt = S_WR_HI;
            S_WR_HI:  nxt = S_FETCH;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_FETCH;
        endcase
    end

    // Outputs are decoded from the state being entered, so they line up with that state's cycle.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state       <= S_FETCH;
            tcnt        <= '0;
            instr_req   <= 1'b1;
            ir_enable   <= 1'b0;
            pc_enable   <= 1'b0;
            ra_enable   <= 1'b0;
            rb_enable   <= 1'b0;
            rm_enable   <= 1'b0;
            rz0_enable  <= 1'b0;
            rz1_enable  <= 1'b0;
            ry_enable   <= 1'b0;
            mb_select   <= 1'b0;
            my_select   <= MY_RZ1;
            alu_control <= ALU_ADD;
            rf_addr_a   <= 4'd0;
            rf_addr_b   <= 4'd0;
            rf_we       <= 1'b0;
            rf_waddr    <= 4'd0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            illegal_op  <= 1'b0;
            bus_error   <= 1'b0;
            halted      <= 1'b0;
            retired     <= '0;
        end else begin
            state       <= nxt;
            tcnt        <= (state == S_MEM) ? tcnt + 32'd1 : '0;
            instr_req   <= (nxt == S_FETCH);
            halted      <= (nxt == S_HALT);
            ir_enable   <= 1'b0;
            pc_enable   <= 1'b0;
            ra_enable   <= 1'b0;
            rb_enable   <= 1'b0;
            rm_enable   <= 1'b0;
            rz0_enable  <= 1'b0;
            rz1_enable  <= 1'b0;
            ry_enable   <= 1'b0;
            mb_select   <= 1'b0;
            my_select   <= MY_RZ1;
            alu_control <= ALU_ADD;
            rf_addr_a   <= 4'd0;
            rf_addr_b   <= 4'd0;
            rf_we       <= 1'b0;
            rf_waddr    <= 4'd0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            illegal_op  <= 1'b0;
            if (mem_timeout) bus_error <= 1'b1;
            if (nxt == S_FETCH && state != S_FETCH && state != S_HALT)
                retired <= retired + 32'd1;
            case (nxt)
                S_DECODE: begin
                    ir_enable  <= 1'b1;
                    pc_enable  <= 1'b1;
                    ra_enable  <= 1'b1;
                    rb_enable  <= 1'b1;
                    rf_addr_a  <= dec_addr_a;
                    rf_addr_b  <= dec_addr_b;
                    illegal_op <= (dec_class == CL_ILL);
                end
                S_EXEC: begin
                    rz0_enable  <= 1'b1;
                    rz1_enable  <= (dec_class == CL_MULDIV);
                    rm_enable   <= (dec_class == CL_ST);
                    mb_select   <= dec_mb;
                    alu_control <= dec_alu;
                end
                S_MEM: begin
                    mem_rd <= (dec_class == CL_LD);
                    mem_wr <= (dec_class == CL_ST);
                end
                S_WB: begin
                    ry_enable <= 1'b1;
                    my_select <= (dec_class == CL_LD) ? MY_MEM : MY_RZ0;
                end
                S_WR: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= dec_ra;
                end
                S_WB_HI: begin
                    ry_enable <= 1'b1;
                    my_select <= MY_RZ1;
                end
                S_WR_HI: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= dec_ra + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minisrc_control.sv
// Bench for minisrc_control: per-instruction expected cycle traces built from the stage rules,
// replayed cycle by cycle against the DUT, plus literal checks on the documented scenarios.
module tb_minisrc_control;

    localparam int T = 4;

    logic        clock_in = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ir_in = '0;
    logic        instr_valid = 1'b0;
    logic        mem_ack = 1'b0;
    logic        instr_req, ir_enable, ra_enable, rb_enable, rm_enable, rz0_enable, rz1_enable, ry_enable;
    logic        mb_select, rf_we, pc_enable, mem_rd, mem_wr, illegal_op, bus_error, halted;
    logic [1:0]  my_select;
    logic [3:0]  alu_control, rf_addr_a, rf_addr_b, rf_waddr;
    logic [31:0] imm_out, retired;

    minisrc_control #(.MEM_TIMEOUT(T)) dut (
        .clock_in(clock_in), .reset(reset), .ir_in(ir_in), .instr_valid(instr_valid), .mem_ack(mem_ack),
        .instr_req(instr_req), .ir_enable(ir_enable), .ra_enable(ra_enable), .rb_enable(rb_enable),
        .rm_enable(rm_enable), .rz0_enable(rz0_enable), .rz1_enable(rz1_enable), .ry_enable(ry_enable),
        .mb_select(mb_select), .my_select(my_select), .alu_control(alu_control), .imm_out(imm_out),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .pc_enable(pc_enable), .mem_rd(mem_rd), .mem_wr(mem_wr), .illegal_op(illegal_op),
        .bus_error(bus_error), .halted(halted), .retired(retired)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic        req, ir_en, pc_en, ra_en, rb_en, rm_en, rz0_en, rz1_en, ry_en, mb;
        logic [1:0]  my;
        logic [3:0]  alu, aa, ab;
        logic        we;
        logic [3:0]  wa;
        logic        rd, wr, ill, berr, hlt;
        logic [31:0] ret;
        logic [31:0] imm;
    } exp_t;

    exp_t        tq[$];
    bit          ivq[$];
    bit          ackq[$];
    int          vecs = 0;
    int          errs = 0;
    logic [31:0] ret_m = '0;
    bit          berr_m = 1'b0;
    bit          halted_m = 1'b0;
    logic [31:0] cur_ir = '0;
    int          first_we, memcnt, both_log, mb_log, my_log, aa_log, ab_log, mem_idx;
    int          wlog[$];
    logic [4:0]  opt [16] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13,
                              5'd14, 5'd15, 5'd16, 5'd26, 5'd27, 5'd1, 5'd9, 5'd31};

    // 0 ld, 1 st, 2 reg-reg, 3 immediate, 4 mul/div, 5 nop, 6 halt, 7 illegal
    function automatic int cls(input logic [4:0] op);
        case (op)
            5'd0: return 0;
            5'd2: return 1;
            5'd3, 5'd4, 5'd5, 5'd6: return 2;
            5'd12, 5'd13, 5'd14: return 3;
            5'd15, 5'd16: return 4;
            5'd26: return 5;
            5'd27: return 6;
            default: return 7;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            5'd4: return 4'd1;
            5'd6, 5'd14: return 4'd2;
            5'd5, 5'd13: return 4'd3;
            5'd15: return 4'd4;
            5'd16: return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ir);
        int v;
        v = int'(ir[18:0]);
        if (ir[18]) v = v - 524288;
        return 32'(v);
    endfunction

    function automatic exp_t base();
        exp_t e;
        e = '0;
        e.berr = berr_m;
        e.ret = ret_m;
        return e;
    endfunction

    task automatic push(input exp_t e, input bit iv, input bit ack);
        tq.push_back(e);
        ivq.push_back(iv);
        ackq.push_back(ack);
    endtask

    task automatic halt_tail(input int h);
        exp_t e;
        halted_m = 1'b1;
        e = base();
        e.hlt = 1'b1;
        repeat (h) push(e, 1'b1, 1'($urandom_range(0, 1)));
    endtask

    // Expected trace of one instruction: w idle FETCH cycles, accept, then its stages; ack after a stalled MEM cycles.
    task automatic gen(input logic [31:0] ir, input int w, input int a, input int h);
        exp_t e;
        int c;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        ir_in = ir;
        cur_ir = ir;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        c = cls(op);
        e = base(); e.req = 1'b1;
        repeat (w) push(e, 1'b0, 1'b0);
        push(e, 1'b1, 1'b0);
        e = base();
        e.ir_en = 1'b1; e.pc_en = 1'b1; e.ra_en = 1'b1; e.rb_en = 1'b1;
        if (c <= 4) e.aa = rb;
        if (c == 2 || c == 4) e.ab = rc;
        else if (c == 1) e.ab = ra;
        e.ill = (c == 7);
        push(e, 1'b0, 1'b0);
        if (c == 6) begin halt_tail(h); return; end
        if (c >= 5) begin ret_m = ret_m + 1; return; end
        e = base();
        e.rz0_en = 1'b1; e.rz1_en = (c == 4); e.rm_en = (c == 1);
        e.mb = (c == 0 || c == 1 || c == 3); e.alu = alu_of(op);
        push(e, 1'b0, 1'b0);
        if (c <= 1) begin
            mem_idx = tq.size();
            e = base(); e.rd = (c == 0); e.wr = (c == 1);
            if (T != 0 && a + 1 > T) begin
                repeat (T) push(e, 1'b0, 1'b0);
                berr_m = 1'b1;
                halt_tail(h);
                return;
            end
            repeat (a) push(e, 1'b0, 1'b0);
            push(e, 1'b0, 1'b1);
            if (c == 1) begin ret_m = ret_m + 1; return; end
        end
        e = base(); e.ry_en = 1'b1; e.my = (c == 0) ? 2'd2 : 2'd1;
        push(e, 1'b0, 1'b0);
        e = base(); e.we = 1'b1; e.wa = ra;
        push(e, 1'b0, 1'b0);
        if (c == 4) begin
            e = base(); e.ry_en = 1'b1; e.my = 2'd0;
            push(e, 1'b0, 1'b0);
            e = base(); e.we = 1'b1; e.wa = ra + 4'd1;
            push(e, 1'b0, 1'b0);
        end
        ret_m = ret_m + 1;
    endtask

    task automatic check_cycle(input exp_t e, input int idx);
        exp_t act;
        e.imm = imm_of(cur_ir);
        act = '0;
        act.req = instr_req; act.ir_en = ir_enable; act.pc_en = pc_enable;
        act.ra_en = ra_enable; act.rb_en = rb_enable; act.rm_en = rm_enable;
        act.rz0_en = rz0_enable; act.rz1_en = rz1_enable; act.ry_en = ry_enable;
        act.mb = mb_select; act.my = my_select; act.alu = alu_control;
        act.aa = rf_addr_a; act.ab = rf_addr_b; act.we = rf_we; act.wa = rf_waddr;
        act.rd = mem_rd; act.wr = mem_wr; act.ill = illegal_op; act.berr = bus_error;
        act.hlt = halted; act.ret = retired; act.imm = imm_out;
        vecs++;
        if (act !== e) begin
            errs++;
            $display("FAIL cycle%0d ir=%h got=%h want=%h", idx, cur_ir, act, e);
        end
        if (rf_we) begin
            if (first_we < 0) first_we = idx;
            wlog.push_back(int'(rf_waddr));
        end
        if (mem_rd || mem_wr) memcnt++;
        if (rz0_enable) begin both_log = int'(rz1_enable); mb_log = int'(mb_select); end
        if (ry_enable && my_log < 0) my_log = int'(my_select);
        if (ra_enable) begin aa_log = int'(rf_addr_a); ab_log = int'(rf_addr_b); end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic play(input int lim);
        first_we = -1; memcnt = 0; both_log = -1; mb_log = -1; my_log = -1; aa_log = -1; ab_log = -1;
        wlog.delete();
        for (int i = 0; i < tq.size() && i < lim; i++) begin
            @(negedge clock_in);
            check_cycle(tq[i], i);
            instr_valid = ivq[i];
            mem_ack = ackq[i];
        end
        @(posedge clock_in);
        #1;
        instr_valid = 1'b0;
        mem_ack = 1'b0;
        tq.delete(); ivq.delete(); ackq.delete();
    endtask

    task automatic do_reset(input bit ack_in);
        exp_t e;
        @(negedge clock_in);
        reset = 1'b1; instr_valid = 1'b0; mem_ack = ack_in;
        @(posedge clock_in);
        #1;
        ret_m = '0; berr_m = 1'b0; halted_m = 1'b0;
        e = base(); e.req = 1'b1;
        check_cycle(e, -1);
        reset = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ir;
        do_reset(1'b0);
        chk("reset_retired", retired, 32'd0);

        gen(32'h19890000, 0, 0, 0); play(1000);
        chk("add_we_cycle", 32'(first_we), 32'd4);
        chk("add_addr_a", 32'(aa_log), 32'd1);
        chk("add_addr_b", 32'(ab_log), 32'd2);
        chk("add_waddr", 32'(wlog[0]), 32'd3);
        chk("add_retired", retired, 32'd1);

        gen(32'h610FFFFC, 1, 0, 0); play(1000);
        chk("addi_imm", imm_out, 32'hFFFFFFFC);
        chk("addi_mb", 32'(mb_log), 32'd1);
        chk("addi_waddr", 32'(wlog[0]), 32'd2);

        gen(32'h02280008, 0, 2, 0); play(1000);
        chk("ld_rd_cycles", 32'(memcnt), 32'd3);
        chk("ld_my", 32'(my_log), 32'd2);
        chk("ld_waddr", 32'(wlog[0]), 32'd4);

        gen(32'h87BC0000, 2, 0, 0); play(1000);
        chk("mul_rz_pair", 32'(both_log), 32'd1);
        chk("mul_writes", 32'(wlog.size()), 32'd2);
        chk("mul_waddr_lo", 32'(wlog[0]), 32'd15);
        chk("mul_waddr_hi", 32'(wlog[wlog.size()-1]), 32'd0);

        for (int n = 0; n < 250; n++) begin
            ir = $urandom;
            ir[31:27] = opt[$urandom_range(0, 15)];
            gen(ir, $urandom_range(0, 2), $urandom_range(0, 5), $urandom_range(1, 3));
            play(1000);
            if (halted_m) do_reset(1'($urandom_range(0, 1)));
        end

        do_reset(1'b0);
        gen(32'h11080004, 0, 10, 3); play(1000);
        chk("st_to_wr_cycles", 32'(memcnt), 32'd4);
        chk("st_to_bus_error", 32'(bus_error), 32'd1);
        chk("st_to_halted", 32'(halted), 32'd1);
        chk("st_to_mem_wr", 32'(mem_wr), 32'd0);

        do_reset(1'b0);
        gen(32'h19890000, 0, 0, 0); play(1000);
        gen(32'h02280008, 0, 3, 0); play(mem_idx + 1);
        do_reset(1'b1);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_instr_req", 32'(instr_req), 32'd1);

        gen(32'h19890000, 0, 0, 0); play(1000);
        gen(32'hD8000000, 1, 0, 20); play(1000);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_instr_req", 32'(instr_req), 32'd0);
        chk("halt_retired", retired, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
